exec_mem_pipe: RTL

//  Parametrised successor to the single-cycle ALU + data-memory backend. Takes one decoded

---
 rtl/exec_mem_pipe.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/exec_mem_pipe.sv
// exec_mem_pipe: ALU plus byte-enabled req/ack data-memory port with a held result register
module exec_mem_pipe #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 15,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          alu_op,
    input  logic [2:0]          mem_op,
    input  logic                is_load,
    input  logic                is_store,
    input  logic [XLEN-1:0]     opa,
    input  logic [XLEN-1:0]     opb,
    input  logic [XLEN-1:0]     st_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_ack,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_data,
    output logic                out_lt,
    output logic                out_ltu,
    output logic                out_zero,
    output logic                out_fault
);
    localparam int BW = XLEN / 8;
    localparam int LB = $clog2(BW);
    localparam int SW = $clog2(XLEN);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [1:0] MAX_SIZE = 2'(LB);
    localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, MREQ, RESP} state_t;
    state_t state, state_nx;

    logic [XLEN-1:0]   sum, alu_res, res, ld_val, shifted, wdata_nx;
    logic [XLEN:0]     diff;
    logic              lt, ltu, ovf, is_mem, misal, accept, tmo;
    logic [1:0]        size;
    logic [3:0]        nbytes;
    logic [8:0]        lanes;
    logic [2:0]        amask;
    logic [BW-1:0]     be_nx;

    logic [XLEN-1:0]   res_q, wdata_q;
    logic              lt_q, ltu_q, zero_q, fault_q, we_q, uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BW-1:0]     be_q;
    logic [LB-1:0]     off_q;
    logic [1:0]        size_q;
    logic [TW-1:0]     cnt;

    assign accept    = (state == IDLE) && in_valid;
    assign is_mem    = is_load | is_store;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESP);
    assign mem_req   = (state == MREQ);
    assign mem_we    = we_q & mem_req;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign out_data  = res_q;
    assign out_lt    = lt_q;
    assign out_ltu   = ltu_q;
    assign out_zero  = zero_q;
    assign out_fault = fault_q;
    assign tmo       = (TIMEOUT != 0) && (cnt == T_LAST);

    // ALU and flags; flags always come from the subtraction regardless of the selected op
    always_comb begin
        sum  = opa + opb;
        diff = {1'b0, opa} - {1'b0, opb};
        ltu  = diff[XLEN];
        ovf  = (opa[XLEN-1] ^ opb[XLEN-1]) & (opa[XLEN-1] ^ diff[XLEN-1]);
        lt   = diff[XLEN-1] ^ ovf;
        case (alu_op)
            4'd1:    alu_res = diff[XLEN-1:0];
            4'd2:    alu_res = opa & opb;
            4'd3:    alu_res = opa | opb;
            4'd4:    alu_res = opa ^ opb;
            4'd5:    alu_res = {{(XLEN-1){1'b0}}, lt};
            4'd6:    alu_res = {{(XLEN-1){1'b0}}, ltu};
            4'd7:    alu_res = opa << opb[SW-1:0];
            4'd8:    alu_res = opa >> opb[SW-1:0];
            4'd9:    alu_res = XLEN'($signed(opa) >>> opb[SW-1:0]);
            default: alu_res = sum;
        endcase
        res = is_mem ? sum : alu_res;
    end

    // Access size, alignment, byte enables and lane-replicated store data for a new request
    always_comb begin
        size   = (mem_op[1:0] > MAX_SIZE) ? MAX_SIZE : mem_op[1:0];
        nbytes = 4'd1 << size;
        lanes  = (9'd1 << nbytes) - 9'd1;
        amask  = 3'(nbytes - 4'd1);
        misal  = |(sum[2:0] & amask);
        be_nx  = BW'({8'b0, lanes[7:0]} << sum[LB-1:0]);
        wdata_nx = '0;
        for (int i = 0; i < BW; i++)
            wdata_nx[8*i +: 8] = st_data[8*(i & int'(amask)) +: 8];
    end

    // Load lane extraction with sign or zero extension
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    ld_val = uns_q ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
            2'd1:    ld_val = uns_q ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            2'd2:    ld_val = uns_q ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            default: ld_val = shifted;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: misaligned accesses skip memory; an ack in the abort cycle still completes
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = (is_mem && !misal) ? MREQ : RESP;
            MREQ:    if (mem_ack || tmo) state_nx = RESP;
            RESP:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Result, flags, memory request fields and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            wdata_q <= '0;
            lt_q    <= 1'b0;
            ltu_q   <= 1'b0;
            zero_q  <= 1'b0;
            fault_q <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            off_q   <= '0;
            size_q  <= '0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                res_q   <= res;
                lt_q    <= lt;
                ltu_q   <= ltu;
                zero_q  <= (res == '0);
                fault_q <= is_mem && misal;
                we_q    <= is_store && !is_load;
                uns_q   <= mem_op[2];
                addr_q  <= sum[ADDR_W+LB-1:LB];
                be_q    <= be_nx;
                wdata_q <= wdata_nx;
                off_q   <= sum[LB-1:0];
                size_q  <= size;
                cnt     <= '0;
            end
            if (state == MREQ) begin
                cnt <= cnt + 1'b1;
                if (mem_ack && !we_q) res_q <= ld_val;
                else if (!mem_ack && tmo) fault_q <= 1'b1;
            end
        end
    end
endmodule
